// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter between the WB stage and a long-latency result FIFO
// Pipeline writes pass through combinationally; buffered results fill idle slots or force a one-cycle stall.
module rf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        ll_valid_i,
  input  logic [4:0]  ll_rd_i,
  input  logic [31:0] ll_data_i,
  output logic        ll_ready_o,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_wd_o,
  output logic        pending_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d, vld_n;
  logic [AW:0]      wp_q, wp_d, rp_q, rp_d, count;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stall_q, stall_d;

  logic          full, pending, head_ok, pw, fifo_gnt, pipe_gnt, store, clr, found;
  logic [AW-1:0] head;
  logic [AW:0]   idx;

  // Invariant: after every edge the entry at rp_q is valid or the FIFO is empty,
  // so the head needs no scan; the scan below trims leading dead entries instead.
  always_comb begin
    full     = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    count    = wp_q - rp_q;
    head     = rp_q[AW-1:0];
    pending  = |vld_q;
    head_ok  = vld_q[head];
    pw       = wb_we_i && (wb_rd_i != 5'd0) && !stall_q;
    fifo_gnt = head_ok && (stall_q || !pw);
    pipe_gnt = pw;

    ll_ready_o = resetn && !full;
    rf_we_o    = resetn && (pipe_gnt || fifo_gnt);
    rf_rd_o    = fifo_gnt ? rd_q[head]   : wb_rd_i;
    rf_wd_o    = fifo_gnt ? data_q[head] : wb_data_i;
    pending_o  = pending;
    stall_o    = stall_q;

    // Entries surviving this edge: drop the popped head and anything the pipeline overwrites.
    for (int i = 0; i < DEPTH; i++) begin
      vld_n[i] = vld_q[i]
                 && !(pipe_gnt && (rd_q[i] == wb_rd_i))
                 && !(fifo_gnt && (AW'(i) == head));
    end

    rp_d  = wp_q;
    found = 1'b0;
    idx   = rp_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp_q + (AW+1)'(k);
      if (!found && ((AW+1)'(k) < count) && vld_n[idx[AW-1:0]]) begin
        rp_d  = idx;
        found = 1'b1;
      end
    end

    store = ll_valid_i && ll_ready_o && (ll_rd_i != 5'd0)
            && !(pipe_gnt && (ll_rd_i == wb_rd_i));
    wp_d  = wp_q + (AW+1)'(store);
    vld_d = vld_n;
    if (store) vld_d[wp_q[AW-1:0]] = 1'b1;

    clr     = stall_q || fifo_gnt || !pending;
    cnt_d   = clr ? '0 : ((cnt_q == CW'(STARVE_LIMIT)) ? cnt_q : cnt_q + CW'(1));
    stall_d = !clr && (cnt_q == CW'(STARVE_LIMIT - 1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      rd_q[wp_q[AW-1:0]]   <= ll_rd_i;
      data_q[wp_q[AW-1:0]] <= ll_data_i;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter with a queue-level reference model
module tb_rf_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        ll_valid_i = 1'b0;
  logic [4:0]  ll_rd_i = '0;
  logic [31:0] ll_data_i = '0;
  logic        ll_ready_o, stall_o, rf_we_o, pending_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wd_o;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .ll_valid_i(ll_valid_i), .ll_rd_i(ll_rd_i), .ll_data_i(ll_data_i),
    .ll_ready_o(ll_ready_o), .stall_o(stall_o), .rf_we_o(rf_we_o),
    .rf_rd_o(rf_rd_o), .rf_wd_o(rf_wd_o), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_stall  = 0;
  logic [31:0] rf_obs [32];

  bit          e_ready, e_fg, e_pg, e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;
  int          e_h;

  // Expected outputs for the current cycle from the model state and the inputs.
  task automatic model_eval();
    bit pwm;
    e_h = -1;
    foreach (mq[i]) if (e_h < 0 && mq[i].v) e_h = i;
    pwm     = wb_we_i && (wb_rd_i != 0) && !m_stall;
    e_fg    = (e_h >= 0) && (m_stall || !pwm);
    e_pg    = pwm && !e_fg;
    e_we    = e_fg || e_pg;
    e_rd    = e_fg ? mq[e_h].rd : wb_rd_i;
    e_wd    = e_fg ? mq[e_h].d  : wb_data_i;
    e_ready = mq.size() < DEPTH;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_starve = 0;
      m_stall  = 0;
    end else begin
      model_eval();
      if (e_fg) mq[e_h].v = 0;
      if (e_pg) foreach (mq[i]) if (mq[i].rd == wb_rd_i) mq[i].v = 0;
      while (mq.size() > 0 && !mq[0].v) void'(mq.pop_front());
      if (m_stall || e_fg || e_h < 0) begin
        m_starve = 0;
        m_stall  = 0;
      end else begin
        if (m_starve < LIMIT) m_starve++;
        m_stall = (m_starve == LIMIT);
      end
      if (ll_valid_i && e_ready && ll_rd_i != 0 && !(e_pg && ll_rd_i == wb_rd_i))
        mq.push_back('{rd: ll_rd_i, d: ll_data_i, v: 1'b1});
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_we", rf_we_o, 0);
      chk("rst_ready", ll_ready_o, 0);
      chk("rst_pending", pending_o, 0);
      chk("rst_stall", stall_o, 0);
    end else begin
      model_eval();
      chk("m_ready", ll_ready_o, e_ready);
      chk("m_stall", stall_o, m_stall);
      chk("m_pending", pending_o, e_h >= 0);
      chk("m_we", rf_we_o, e_we);
      if (e_we) begin
        chk("m_rd", rf_rd_o, e_rd);
        chk("m_wd", rf_wd_o, e_wd);
      end
      if (rf_we_o) rf_obs[rf_rd_o] = rf_wd_o;
    end
  end

  task automatic step(input bit we, input int rd, input int wd,
                      input bit lv, input int lrd, input int lwd);
    @(posedge clk);
    #1;
    wb_we_i = we; wb_rd_i = 5'(rd); wb_data_i = wd;
    ll_valid_i = lv; ll_rd_i = 5'(lrd); ll_data_i = lwd;
    #2;
  endtask

  initial begin
    #3;
    chk("in_rst_ready", ll_ready_o, 0);
    chk("in_rst_we", rf_we_o, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #2;
    chk("rel_ready", ll_ready_o, 1);
    chk("rel_stall", stall_o, 0);
    chk("rel_we", rf_we_o, 0);

    step(1, 5, 32'h1234, 0, 0, 0);
    chk("pass_we", rf_we_o, 1);
    chk("pass_rd", rf_rd_o, 5);
    chk("pass_wd", rf_wd_o, 32'h1234);

    step(0, 0, 0, 1, 7, 32'hDEAD);
    chk("ll7_same_cycle_we", rf_we_o, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("ll7_we", rf_we_o, 1);
    chk("ll7_rd", rf_rd_o, 7);
    chk("ll7_wd", rf_wd_o, 32'hDEAD);
    step(0, 0, 0, 0, 0, 0);
    chk("ll7_pending_clr", pending_o, 0);

    step(1, 10, 32'hA0, 1, 3, 32'h33);
    step(1, 10, 32'hA1, 1, 4, 32'h44);
    step(1, 10, 32'hA2, 0, 0, 0);
    chk("full_ready", ll_ready_o, 0);
    chk("no_stall_c", stall_o, 0);
    step(1, 10, 32'hA3, 0, 0, 0);
    step(1, 10, 32'hA4, 0, 0, 0);
    chk("no_stall_e", stall_o, 0);
    step(1, 10, 32'hA4, 0, 0, 0);
    chk("stall1", stall_o, 1);
    chk("stall1_rd", rf_rd_o, 3);
    chk("stall1_wd", rf_wd_o, 32'h33);
    step(1, 10, 32'hA5, 0, 0, 0);
    chk("stall1_one_cycle", stall_o, 0);
    chk("ready_after_pop", ll_ready_o, 1);
    repeat (3) step(1, 10, 32'hA6, 0, 0, 0);
    step(1, 10, 32'hA6, 0, 0, 0);
    chk("stall2", stall_o, 1);
    chk("stall2_rd", rf_rd_o, 4);
    step(0, 0, 0, 0, 0, 0);
    chk("drained", pending_o, 0);

    step(0, 0, 0, 1, 9, 32'h99);
    step(1, 9, 32'h1, 0, 0, 0);
    chk("squash_we", rf_we_o, 1);
    chk("squash_wd", rf_wd_o, 32'h1);
    step(0, 0, 0, 0, 0, 0);
    chk("squash_idle_we", rf_we_o, 0);
    chk("squash_pending", pending_o, 0);
    chk("x9_value", rf_obs[9], 32'h1);

    step(1, 0, 32'h55, 1, 0, 32'h66);
    chk("x0_we", rf_we_o, 0);
    chk("x0_ready", ll_ready_o, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("x0_pending", pending_o, 0);

    step(1, 10, 32'hB0, 1, 11, 32'hC1);
    step(1, 10, 32'hB1, 1, 12, 32'hC2);
    step(1, 10, 32'hB2, 0, 0, 0);
    chk("fill_pending", pending_o, 1);
    chk("fill_ready", ll_ready_o, 0);
    resetn = 1'b0;
    #1;
    chk("async_we", rf_we_o, 0);
    chk("async_pending", pending_o, 0);
    chk("async_ready", ll_ready_o, 0);
    step(0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    repeat (4) begin
      step(0, 0, 0, 0, 0, 0);
      chk("post_rst_we", rf_we_o, 0);
      chk("post_rst_pending", pending_o, 0);
    end

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 4), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 400) == 0) begin
        resetn = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
      end
    end
    step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline write-back stage and out-of-order results from the long-latency unit (divider / multi-cycle load).
- Long-latency results are buffered in a small FIFO and drained into idle write-back slots.
- A starvation counter forces a one-cycle pipeline stall so buffered results always retire.
- Sits between the WB stage and the RF write port in ID.

Parameters:
- DEPTH, 2, number of long-latency result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive non-granted cycles with FIFO non-empty before a stall is forced (≥1).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- wb_we_i  in  1  pipeline write-back enable.
- wb_rd_i  in  5  pipeline destination register index.
- wb_data_i  in  32  pipeline write-back data.
- ll_valid_i  in  1  long-latency result valid.
- ll_rd_i  in  5  long-latency destination index.
- ll_data_i  in  32  long-latency result data.
- ll_ready_o  out  1  FIFO can accept; transfer occurs when ll_valid_i & ll_ready_o.
- stall_o  out  1  registered; when high, WB stage must hold its inputs this cycle.
- rf_we_o  out  1  RF write enable.
- rf_rd_o  out  5  RF write index.
- rf_wd_o  out  32  RF write data.
- pending_o  out  1  FIFO non-empty.

Behaviour:
- Reset (resetn low, async): FIFO empty, read/write pointers 0, starvation counter 0, stall_o=0. While in reset, rf_we_o=0, ll_ready_o=0 and pending_o=0. After release: ll_ready_o=1.
- Effective pipeline request: pw = wb_we_i & (wb_rd_i != 0) & ~stall_o. Writes to x0 never reach the RF.
- Grant, decided combinationally each cycle:
  - stall_o=1 → FIFO head.
  - else pw → pipeline.
  - else FIFO non-empty → FIFO head.
  - else none, rf_we_o=0.
- Granted FIFO head: rf_rd_o/rf_wd_o come from the head entry, the head is popped at the clock edge, rf_we_o=1. When not granted, rf_rd_o/rf_wd_o are don't-care.
- Pipeline write is zero-latency (combinational pass-through); a FIFO entry retires no earlier than the cycle after it is enqueued.
- Enqueue:
  - ll_ready_o = ~full. This is registered-state based and does not consider a same-cycle pop.
  - An entry with ll_rd_i==0 is accepted (handshake completes) but not stored.
- Squash (WAW ordering):
  - When pw is granted with rd=R, every valid FIFO entry with rd==R is invalidated at that edge.
  - An ll result with ll_rd_i==R accepted in the same cycle is also dropped; its handshake still completes.
  - Invalidated entries are skipped when reaching the head: popped without writing, taking no grant cycle. Head selection therefore skips invalid entries combinationally. With DEPTH entries, a scan over at most DEPTH entries is acceptable.
- Starvation counter:
  - Increments each cycle the FIFO holds a valid entry and the FIFO is not granted, saturating at STARVE_LIMIT.
  - Clears on any FIFO grant or when the FIFO is empty.
  - stall_o is set at the edge where the counter reaches STARVE_LIMIT, and clears at the following edge (exactly one cycle high).
  - Counter clears when stall_o is high.
- Simultaneous events: enqueue and pop in the same cycle are both performed. The full→not-full transition is visible on ll_ready_o only the next cycle.
- pending_o = any valid entry in the FIFO.
- Pointer wrap: pointers are log2(DEPTH)+1 bits with an MSB wrap flag. full = indices equal & flags differ.
- Reset mid-operation: all queued results are discarded and no RF write occurs during reset.

Test Plan:
- Reset release, no traffic → ll_ready_o=1, stall_o=0, rf_we_o=0. Then wb_we_i=1, rd=5, data=0x1234 → same cycle rf_we_o=1, rf_rd_o=5, rf_wd_o=0x1234.
- Enqueue ll rd=7, data=0xDEAD with wb_we_i=0 → next cycle rf_we_o=1, rd=7, data=0xDEAD, then pending_o=0.
- Enqueue two results (rd=3, rd=4) while pipeline writes every cycle → ll_ready_o=0 after the second accept. After 4 non-granted cycles stall_o=1 for exactly one cycle, writing rd=3. The next stall writes rd=4.
- Enqueue ll rd=9; next cycle pipeline writes rd=9, data=0x1 → entry squashed. Later idle cycle: rf_we_o stays 0 and RF x9 holds 0x1.
- Pipeline wb_we_i=1, rd=0; ll rd=0 valid → rf_we_o=0, ll handshake completes, pending_o=0.
- Fill FIFO, assert resetn=0 mid-cycle → outputs reset immediately. After release: pending_o=0, no RF writes for the discarded entries.
